apex_register_arbiter: RTL and testbench
========================================

APEX_REGISTER_ARBITER -- requirements
Module: apex_register_arbiter

Interface
REQ-001 Parameter ADDR_W, 8, address width shared by masters and slave port.
REQ-002 Parameter DATA_W, 32, data width shared by masters and slave port.
REQ-003 Parameter READ_LATENCY, 1, slave cycles from sampled address to valid s_readdata; legal range 1..7.
REQ-004 The clock port SHALL be clk, input, 1, single clock for all state.
REQ-005 The reset port SHALL be rst, input, 1; reset is asynchronous and active-high.
REQ-006 mN_read / mN_write (N=0,1) SHALL be inputs, 1 bit each: master N transfer request, held until waitrequest low.
REQ-007 mN_address SHALL be an input, ADDR_W bits; mN_writedata SHALL be an input, DATA_W bits.
REQ-008 mN_waitrequest SHALL be an output, 1 bit: stall to master N.
REQ-009 mN_readdata SHALL be an output, DATA_W bits: read result, valid when waitrequest is low on a read.
REQ-010 s_chipselect, s_read, s_write SHALL be outputs, 1 bit each, driving the register-bank slave.
REQ-011 s_address SHALL be an output, ADDR_W bits; s_writedata SHALL be an output, DATA_W bits.
REQ-012 s_readdata SHALL be an input, DATA_W bits, from the slave.
REQ-013 grant SHALL be an output, 2 bits, one-hot current owner (bit N = master N), 0 when idle; busy SHALL be an output, 1 bit, high when state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, WR, RD, RWAIT, DONE.
REQ-015 IDLE: if any mN_read|mN_write is high, the arbiter SHALL latch the owner and go to WR (write) or RD (read); otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: a single requester wins; with both requesting, the master not granted last wins; last_grant resets to 1, so m0 wins the first tie.
REQ-017 If the owner asserts read and write together, write SHALL take precedence.
REQ-018 WR: one cycle; s_chipselect=1, s_write=1, s_address/s_writedata muxed from owner; next state DONE.
REQ-019 RD: one cycle; s_chipselect=1, s_read=1, s_address from owner; a latency counter SHALL load READ_LATENCY; next state RWAIT.
REQ-020 RWAIT: s_chipselect=1, s_read=0, s_address held from owner; the counter SHALL decrement each cycle; when the counter equals 1, s_readdata SHALL be captured into rdata_q and the next state SHALL be DONE.
REQ-021 DONE: one cycle; owner waitrequest SHALL be 0; owner readdata SHALL be rdata_q; next state IDLE unconditionally.
REQ-022 mN_waitrequest SHALL equal (mN_read|mN_write) AND NOT (state==DONE AND grant[N]); this is combinational.
REQ-023 Outside DONE, or for the non-owner, mN_readdata SHALL hold rdata_q; it SHALL never be X after reset.
REQ-024 Latency from request (sampled in IDLE) to waitrequest low SHALL be 2 cycles for writes and 2+READ_LATENCY cycles for reads.
REQ-025 All s_* outputs SHALL be 0 in IDLE and DONE; s_writedata and s_address SHALL be 0 when not driven.
REQ-026 A request withdrawn mid-transaction (protocol violation) SHALL not abort the transaction; the slave access completes and the DONE acknowledge is dropped.
REQ-027 A request arriving during a transaction SHALL wait; it is arbitrated in the next IDLE.
REQ-028 Addresses SHALL pass through unmodified; there is no range checking.

Reset
REQ-029 rst high SHALL asynchronously force state=IDLE, grant=0, busy=0, last_grant=1, rdata_q=0, counter=0, and all s_* outputs to 0.
REQ-030 During reset, mN_waitrequest SHALL be high whenever mN_read|mN_write is high.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction; no acknowledge is issued; the master must retry.

Verification
REQ-032 m0 write addr 0x02 data 0xDEADBEEF -> s_write=1 for exactly 1 cycle with s_address=0x02; m0_waitrequest low in cycle 2; subsequent m1 read of 0x02 -> m1_readdata=0xDEADBEEF.
REQ-033 m0 and m1 both write continuously from reset -> grants alternate m0, m1, m0, ...; the slave sees an s_write pulse once every 3 cycles.
REQ-034 READ_LATENCY=3; m1 reads 0x01 while slave holds 0x00000055 -> waitrequest low exactly 5 cycles after the request; readdata=0x00000055.
REQ-035 m0 asserts read and write together at address 0x03 -> only s_write is asserted; s_read stays 0.
REQ-036 rst pulses during RWAIT -> state returns to IDLE and outputs go to 0 immediately; no DONE cycle occurs; the master retry completes normally.

Source files
------------

// File: rtl/apex_register_arbiter.sv
// Two-master round-robin arbiter in front of a single register-bank slave.
// Registered slave-side outputs; combinational master waitrequest.
module apex_register_arbiter #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              s_chipselect,
    output logic              s_read,
    output logic              s_write,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam logic [2:0] RdLat = 3'(READ_LATENCY);

    typedef enum logic [2:0] {StIdle, StWr, StRd, StRwait, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              cs_q, cs_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              req0, req1, win1, own_write;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;
    // last_q == 1 means m1 owned last, so m0 wins a tie.
    assign win1      = req1 & (~req0 | ~last_q);
    assign own_write = win1 ? m1_write : m0_write;
    assign own_addr  = win1 ? m1_address : m0_address;
    assign own_wdata = win1 ? m1_writedata : m0_writedata;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        cs_d    = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    grant_d = win1 ? 2'b10 : 2'b01;
                    last_d  = win1;
                    busy_d  = 1'b1;
                    cs_d    = 1'b1;
                    addr_d  = own_addr;
                    if (own_write) begin
                        state_d = StWr;
                        wr_d    = 1'b1;
                        wdata_d = own_wdata;
                    end else begin
                        state_d = StRd;
                        rd_d    = 1'b1;
                    end
                end
            end
            StWr: state_d = StDone;
            StRd: begin
                state_d = StRwait;
                cnt_d   = RdLat;
                cs_d    = 1'b1;
                addr_d  = addr_q;
            end
            StRwait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = s_readdata;
                    state_d = StDone;
                end else begin
                    cs_d   = 1'b1;
                    addr_d = addr_q;
                end
            end
            StDone: begin
                state_d = StIdle;
                grant_d = 2'b00;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
            cnt_q   <= 3'd0;
            cs_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign m0_waitrequest = req0 & ~((state_q == StDone) & grant_q[0]);
    assign m1_waitrequest = req1 & ~((state_q == StDone) & grant_q[1]);
    assign m0_readdata    = rdata_q;
    assign m1_readdata    = rdata_q;
    assign s_chipselect   = cs_q;
    assign s_read         = rd_q;
    assign s_write        = wr_q;
    assign s_address      = addr_q;
    assign s_writedata    = wdata_q;
    assign grant          = grant_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_apex_register_arbiter.sv
// Directed bench for apex_register_arbiter with READ_LATENCY=3 and a simple
// register-bank slave whose read data follows s_address.
module tb_apex_register_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [7:0]  m0_address, m1_address;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        s_chipselect, s_read, s_write;
    logic [7:0]  s_address;
    logic [31:0] s_writedata, s_readdata;
    logic [1:0]  grant;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int c;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_chipselect && s_write) mem[s_address] <= s_writedata;
    end
    assign s_readdata = mem[s_address];

    apex_register_arbiter #(
        .ADDR_W(8),
        .DATA_W(32),
        .READ_LATENCY(3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_address     (m0_address),
        .m0_writedata   (m0_writedata),
        .m0_waitrequest (m0_waitrequest),
        .m0_readdata    (m0_readdata),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_address     (m1_address),
        .m1_writedata   (m1_writedata),
        .m1_waitrequest (m1_waitrequest),
        .m1_readdata    (m1_readdata),
        .s_chipselect   (s_chipselect),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_address      (s_address),
        .s_writedata    (s_writedata),
        .s_readdata     (s_readdata),
        .grant          (grant),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles until master n sees waitrequest low; -1 on timeout.
    task automatic wait_ack(input int n, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (((n == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_read = 0; m0_write = 0; m0_address = 0; m0_writedata = 0;
        m1_read = 0; m1_write = 0; m1_address = 0; m1_writedata = 0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_scs", {s_chipselect, s_read, s_write}, 0);
        chk("rst_saddr", s_address, 0);
        chk("rst_swdata", s_writedata, 0);
        chk("rst_rdata0", m0_readdata, 0);
        chk("rst_rdata1", m1_readdata, 0);
        chk("rst_wait_noreq", {m0_waitrequest, m1_waitrequest}, 0);

        // Both masters write continuously from reset.
        m0_address = 8'h10; m0_writedata = 32'hAAAA0000; m0_write = 1;
        m1_address = 8'h11; m1_writedata = 32'hBBBB1111; m1_write = 1;
        #1;
        chk("rst_wait_req", {m0_waitrequest, m1_waitrequest}, 2'b11);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("rr_grant", grant, (i % 3 == 2) ? 2'b00 : (((i / 3) % 2 == 1) ? 2'b10 : 2'b01));
            chk("rr_swrite", s_write, (i % 3 == 0));
            chk("rr_wait0", m0_waitrequest, !((i % 3 == 1) && ((i / 3) % 2 == 0)));
        end
        m0_write = 0; m1_write = 0;
        tick();
        chk("idle_busy", busy, 0);

        // m0 write 0x02 <- DEADBEEF, then m1 reads it back.
        m0_address = 8'h02; m0_writedata = 32'hDEADBEEF; m0_write = 1;
        #1 chk("wr_wait_c0", m0_waitrequest, 1);
        tick();
        chk("wr_s_ctl", {s_chipselect, s_read, s_write}, 3'b101);
        chk("wr_s_addr", s_address, 8'h02);
        chk("wr_s_wdata", s_writedata, 32'hDEADBEEF);
        chk("wr_grant", grant, 2'b01);
        chk("wr_busy", busy, 1);
        chk("wr_wait_c1", m0_waitrequest, 1);
        tick();
        chk("wr_done_ctl", {s_chipselect, s_read, s_write}, 0);
        chk("wr_done_addr", s_address, 0);
        chk("wr_done_wdata", s_writedata, 0);
        chk("wr_wait_c2", m0_waitrequest, 0);
        m0_write = 0;
        tick();
        chk("wr_idle_grant", grant, 0);

        m1_address = 8'h02; m1_read = 1;
        tick();
        chk("rd_s_ctl", {s_chipselect, s_read, s_write}, 3'b110);
        chk("rd_s_addr", s_address, 8'h02);
        chk("rd_grant", grant, 2'b10);
        tick();
        chk("rwait_s_ctl", {s_chipselect, s_read, s_write}, 3'b100);
        chk("rwait_s_addr", s_address, 8'h02);
        chk("rwait_wait", m1_waitrequest, 1);
        wait_ack(1, c);
        chk("rd_remaining_lat", c, 3);
        chk("rd_data", m1_readdata, 32'hDEADBEEF);
        m1_read = 0;
        tick();

        // Latency 2 for a write, 2+3 for a read.
        m1_address = 8'h01; m1_writedata = 32'h00000055; m1_write = 1;
        wait_ack(1, c);
        chk("wr_lat", c, 2);
        m1_write = 0;
        tick();
        m1_read = 1;
        wait_ack(1, c);
        chk("rd_lat", c, 5);
        chk("rd_data55", m1_readdata, 32'h00000055);
        m1_read = 0;
        tick();

        // Read and write together: write wins.
        m0_address = 8'h03; m0_writedata = 32'h00001234; m0_read = 1; m0_write = 1;
        tick();
        chk("rw_s_ctl", {s_chipselect, s_read, s_write}, 3'b101);
        chk("rw_s_addr", s_address, 8'h03);
        tick();
        chk("rw_wait", m0_waitrequest, 0);
        m0_read = 0; m0_write = 0;
        tick();

        // Withdrawn request still completes the slave write.
        m1_address = 8'h05; m1_writedata = 32'h00000077; m1_write = 1;
        tick();
        m1_write = 0;
        tick();
        chk("wd_busy_done", busy, 1);
        chk("wd_wait", m1_waitrequest, 0);
        tick();
        chk("wd_busy_idle", busy, 0);
        m0_address = 8'h05; m0_read = 1;
        wait_ack(0, c);
        chk("wd_rd_lat", c, 5);
        chk("wd_rd_data", m0_readdata, 32'h00000077);
        m0_read = 0;
        tick();

        // Reset during RWAIT abandons the read; retry completes.
        m0_address = 8'h01; m0_read = 1;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_grant", grant, 0);
        chk("mr_s_ctl", {s_chipselect, s_read, s_write}, 0);
        chk("mr_s_addr", s_address, 0);
        chk("mr_wait", m0_waitrequest, 1);
        chk("mr_rdata", m0_readdata, 0);
        #1 rst = 1'b0;
        wait_ack(0, c);
        chk("mr_retry_lat", c, 5);
        chk("mr_retry_data", m0_readdata, 32'h00000055);
        m0_read = 0;
        tick();
        chk("end_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
